// File: rtl/alu_pipe_pkg.sv
// Shared opcode constants, lane-width encodings, FSM states and the lane-width helper
// used by alu_pipe and alu_pipe_mul.
package alu_pipe_pkg;

  localparam logic [5:0] OP_AND  = 6'h00;
  localparam logic [5:0] OP_OR   = 6'h01;
  localparam logic [5:0] OP_XOR  = 6'h02;
  localparam logic [5:0] OP_NOT  = 6'h03;
  localparam logic [5:0] OP_MOV  = 6'h04;
  localparam logic [5:0] OP_ADD  = 6'h05;
  localparam logic [5:0] OP_SUB  = 6'h06;
  localparam logic [5:0] OP_MULE = 6'h07;
  localparam logic [5:0] OP_MULO = 6'h08;
  localparam logic [5:0] OP_SLL  = 6'h09;
  localparam logic [5:0] OP_SRL  = 6'h0A;
  localparam logic [5:0] OP_SRA  = 6'h0B;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned lane_width(input logic [1:0] w);
    return 32'd8 << w;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative lane multiplier: retires MUL_STEP multiplier bits per step for every
// lane pair in parallel; result is the accumulator plus the current step's partial.
module alu_pipe_mul
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DW       = 64,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    ww,
  input  logic          odd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          done
);

  logic [DW-1:0] mcand_q, mplier_q, acc_q;
  logic [DW-1:0] mcand_d, mplier_d, partial, rep;
  logic [5:0]    cnt_q;
  logic [1:0]    ww_q;
  int unsigned   lw_in, lw_q;

  assign lw_in = lane_width(ww);
  assign lw_q  = lane_width(ww_q);

  // Selected lane of each pair is zero-extended into the pair's 2L-bit span, so
  // whole-vector shifts and adds never carry across pairs.
  always_comb begin
    mcand_d  = '0;
    mplier_d = '0;
    for (int unsigned n = 0; n < DW; n++) begin
      if ((n & (2 * lw_in - 1)) < lw_in) begin
        mcand_d[n]  = odd ? a[n] : a[n + lw_in];
        mplier_d[n] = odd ? b[n] : b[n + lw_in];
      end
    end
  end

  always_comb begin
    partial = '0;
    rep     = '0;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      for (int unsigned n = 0; n < DW; n++) begin
        rep[n] = mplier_q[(n & ~(2 * lw_q - 1)) + j];
      end
      partial = partial + ((mcand_q << j) & rep);
    end
  end

  assign result = acc_q + partial;
  assign done   = (cnt_q == 6'(lw_q / MUL_STEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ww_q     <= '0;
    end else if (start) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= '0;
      cnt_q    <= '0;
      ww_q     <= ww;
    end else if (step) begin
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      acc_q    <= result;
      cnt_q    <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Lane-partitioned ALU with valid/ready handshake. Define ALU_PIPE_MUL_EN to enable
// the iterative MULE/MULO path; otherwise those opcodes report err.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DW       = 64,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    aluType,
  input  logic [1:0]    ww,
  input  logic [4:0]    imm,
  input  logic [0:DW-1] oprA,
  input  logic [0:DW-1] oprB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:DW-1] dout,
  output logic          err
);

  localparam logic [DW-1:0] HI_MASK = {(DW/64){64'hFFFF_FFFF_0000_0000}};

  state_e state_q, state_d;
  logic [DW-1:0] a_in, b_in, a_q, b_q, dout_q;
  logic [DW-1:0] add_a, add_b, add_sum, shl, shr, sra, single_res, mul_result;
  logic [DW/64-1:0] lc_q, lo_carry;
  logic err_q, sub_q, add_sub, accept, is_mul, is_addsub, illegal, multi;
  logic mul_busy, mul_done, busy_last;
  int unsigned lw, sh, seg;

  assign a_in      = oprA;
  assign b_in      = oprB;
  assign lw        = lane_width(ww);
  assign sh        = 32'(imm) & (lw - 1);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (aluType == OP_MULE) || (aluType == OP_MULO);
  assign is_addsub = (aluType == OP_ADD) || (aluType == OP_SUB);

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_AVAIL = 1'b1;
  logic mul_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mul_q <= 1'b0;
    else if (accept) mul_q <= is_mul && !illegal;
  end

  assign mul_busy = (state_q == S_BUSY) && mul_q;

  alu_pipe_mul #(.DW(DW), .MUL_STEP(MUL_STEP)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul && !illegal),
    .step  (mul_busy),
    .ww    (ww),
    .odd   (aluType == OP_MULO),
    .a     (a_in),
    .b     (b_in),
    .result(mul_result),
    .done  (mul_done)
  );
`else
  localparam bit MUL_AVAIL = 1'b0;
  assign mul_busy   = 1'b0;
  assign mul_done   = 1'b1;
  assign mul_result = '0;
`endif

  assign illegal   = (aluType > OP_SRA) || (is_mul && (ww == WW_64 || !MUL_AVAIL));
  assign multi     = !illegal && (is_mul || (is_addsub && ww == WW_64));
  assign busy_last = mul_busy ? mul_done : 1'b1;

  // One byte-rippled adder serves both passes: 64-bit lanes split at 32 bits, the
  // BUSY pass re-adds the upper halves from captured operands with the saved carry.
  assign add_sub = (state_q == S_BUSY) ? sub_q : (aluType == OP_SUB);
  assign add_a   = (state_q == S_BUSY) ? a_q : a_in;
  assign add_b   = add_sub ? ~((state_q == S_BUSY) ? b_q : b_in)
                           :  ((state_q == S_BUSY) ? b_q : b_in);
  assign seg     = (state_q == S_BUSY || ww == WW_64) ? 32'd32 : lw;

  always_comb begin
    logic       c;
    logic [8:0] t;
    add_sum  = '0;
    lo_carry = '0;
    c        = 1'b0;
    for (int unsigned i = 0; i < DW/8; i++) begin
      if (((i * 8) & (seg - 1)) == 0) c = (state_q == S_BUSY) ? lc_q[i/8] : add_sub;
      t = {1'b0, add_a[i*8 +: 8]} + {1'b0, add_b[i*8 +: 8]} + {8'b0, c};
      add_sum[i*8 +: 8] = t[7:0];
      c = t[8];
      if ((i % 8) == 3) lo_carry[i/8] = c;
    end
  end

  always_comb begin
    int unsigned base, pos;
    shl = '0;
    shr = '0;
    sra = '0;
    for (int unsigned n = 0; n < DW; n++) begin
      base = n & ~(lw - 1);
      pos  = n - base;
      if (pos >= sh) shl[n] = a_in[n - sh];
      if (pos + sh < lw) begin
        shr[n] = a_in[n + sh];
        sra[n] = a_in[n + sh];
      end else begin
        sra[n] = a_in[base + lw - 1];
      end
    end
  end

  always_comb begin
    single_res = '0;
    case (aluType)
      OP_AND:         single_res = a_in & b_in;
      OP_OR:          single_res = a_in | b_in;
      OP_XOR:         single_res = a_in ^ b_in;
      OP_NOT:         single_res = ~a_in;
      OP_MOV:         single_res = a_in;
      OP_ADD, OP_SUB: single_res = add_sum;
      OP_SLL:         single_res = shl;
      OP_SRL:         single_res = shr;
      OP_SRA:         single_res = sra;
      default:        single_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = multi ? S_BUSY : S_DONE;
      S_BUSY: if (busy_last) state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = multi ? S_BUSY : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      err_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      lc_q   <= '0;
    end else if (accept) begin
      a_q    <= a_in;
      b_q    <= b_in;
      sub_q  <= (aluType == OP_SUB);
      lc_q   <= lo_carry;
      err_q  <= illegal;
      dout_q <= (illegal || is_mul) ? '0 : single_res;
    end else if (state_q == S_BUSY) begin
      if (mul_busy) begin
        if (mul_done) dout_q <= mul_result;
      end else begin
        dout_q <= (add_sum & HI_MASK) | (dout_q & ~HI_MASK);
      end
    end
  end

  assign dout = dout_q;
  assign err  = err_q;

endmodule
